// File: rtl/jt51_lfo_rate.sv
// JT51 LFO rate generator: fractional mantissa prescaler feeding a power-of-two
// exponent counter; every event toggles the base square wave and pulses tick.
module jt51_lfo_rate (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic [7:0]  lfrq,
  input  logic        lfo_rst,
  output logic        base,
  output logic        tick,
  output logic [14:0] cnt
);

  logic [4:0]  r_acc;
  logic [14:0] r_cnt;
  logic        r_base;
  logic        r_tick;

  logic [5:0]  w_sum;
  logic        w_p;
  logic [14:0] w_mask;
  logic        w_ev;

  // Prescaler carry: average rate (16+m)/32 per enabled cycle
  assign w_sum  = {1'b0, r_acc} + 6'd16 + {2'b00, lfrq[3:0]};
  assign w_p    = w_sum[5];
  // Exponent e selects how many low counter bits must be all-ones; e=15 fires on every carry
  assign w_mask = 15'h7FFF >> lfrq[7:4];
  assign w_ev   = w_p && ((r_cnt & w_mask) == w_mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= 5'd0;
      r_cnt  <= 15'd0;
      r_base <= 1'b0;
      r_tick <= 1'b0;
    end else if (lfo_rst) begin
      // Phase clear keeps base so the LFSR sees no spurious edge
      r_acc  <= 5'd0;
      r_cnt  <= 15'd0;
      r_tick <= 1'b0;
    end else if (cen) begin
      r_acc  <= w_sum[4:0];
      if (w_p) r_cnt <= r_cnt + 15'd1;
      if (w_ev) r_base <= ~r_base;
      r_tick <= w_ev;
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign base = r_base;
  assign tick = r_tick;
  assign cnt  = r_cnt;

endmodule

// File: tb/tb_jt51_lfo_rate.sv
// Directed-vector bench for jt51_lfo_rate; expected values are hand-derived
// from the prescaler/exponent arithmetic.
module tb_jt51_lfo_rate;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cen = 1'b0;
  logic [7:0]  lfrq = 8'h00;
  logic        lfo_rst = 1'b0;
  logic        base;
  logic        tick;
  logic [14:0] cnt;

  int n_vec = 0;
  int n_err = 0;

  jt51_lfo_rate dut (
    .clk     (clk),
    .rst     (rst),
    .cen     (cen),
    .lfrq    (lfrq),
    .lfo_rst (lfo_rst),
    .base    (base),
    .tick    (tick),
    .cnt     (cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input logic c, input logic l);
    cen = c;
    lfo_rst = l;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  // lfrq=0xF0: toggle on every even cen, cnt = k/2
  task automatic run_f0(input string nm);
    logic eb, et;
    logic [14:0] ec;
    lfrq = 8'hF0;
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b0);
      et = (k % 2 == 0);
      eb = ((k / 2) % 2) == 1;
      ec = 15'(k / 2);
      n_vec++;
      if (tick !== et) begin
        n_err++;
        $display("FAIL %s tick cen#%0d: got %b want %b", nm, k, tick, et);
      end
      n_vec++;
      if (base !== eb) begin
        n_err++;
        $display("FAIL %s base cen#%0d: got %b want %b", nm, k, base, eb);
      end
      n_vec++;
      if (cnt !== ec) begin
        n_err++;
        $display("FAIL %s cnt cen#%0d: got %h want %h", nm, k, cnt, ec);
      end
    end
  endtask

  task automatic test_reset();
    lfrq = 8'hF0;
    rst = 1'b1;
    step(1'b1, 1'b0);
    rst = 1'b0;
    n_vec++;
    if ({base, tick, cnt} !== 17'd0) begin
      n_err++;
      $display("FAIL reset_state: got base=%b tick=%b cnt=%h want 0 0 0000", base, tick, cnt);
    end
  endtask

  task automatic test_basic();
    do_reset();
    run_f0("e15m0");
  endtask

  task automatic test_fast();
    int ticks = 0;
    do_reset();
    lfrq = 8'hFF;
    for (int k = 1; k <= 32; k++) begin
      step(1'b1, 1'b0);
      if (tick) ticks++;
    end
    n_vec++;
    if (ticks != 31) begin
      n_err++;
      $display("FAIL e15m15_ticks: got %0d want 31", ticks);
    end
    n_vec++;
    if (cnt !== 15'd31) begin
      n_err++;
      $display("FAIL e15m15_cnt: got %h want 001f", cnt);
    end
    // Accumulator back at 0: next cen sums to 31, no carry
    step(1'b1, 1'b0);
    n_vec++;
    if (tick !== 1'b0) begin
      n_err++;
      $display("FAIL e15m15_acc_wrap: got tick=%b want 0", tick);
    end
  endtask

  task automatic test_e14();
    logic et;
    do_reset();
    lfrq = 8'hE0;
    for (int k = 1; k <= 12; k++) begin
      step(1'b1, 1'b0);
      et = (k % 4 == 0);
      n_vec++;
      if (tick !== et || cnt !== 15'(k / 2)) begin
        n_err++;
        $display("FAIL e14_seq cen#%0d: got tick=%b cnt=%h want tick=%b cnt=%h",
                 k, tick, cnt, et, 15'(k / 2));
      end
    end
    n_vec++;
    if (base !== 1'b1) begin
      n_err++;
      $display("FAIL e14_base: got %b want 1", base);
    end
  endtask

  task automatic test_slow();
    int early = 0;
    do_reset();
    lfrq = 8'h00;
    for (int k = 1; k < 65536; k++) begin
      step(1'b1, 1'b0);
      if (tick) early++;
    end
    n_vec++;
    if (early != 0 || cnt !== 15'h7FFF) begin
      n_err++;
      $display("FAIL e0_before: got early=%0d cnt=%h want 0 7fff", early, cnt);
    end
    step(1'b1, 1'b0);
    n_vec++;
    if (tick !== 1'b1 || base !== 1'b1 || cnt !== 15'd0) begin
      n_err++;
      $display("FAIL e0_at65536: got tick=%b base=%b cnt=%h want 1 1 0000", tick, base, cnt);
    end
  endtask

  task automatic test_cen_toggle();
    logic eb, et;
    logic [14:0] ec;
    do_reset();
    lfrq = 8'hF0;
    for (int h = 1; h <= 8; h++) begin
      step(1'b1, 1'b0);
      et = (h % 2 == 0);
      eb = ((h / 2) % 2) == 1;
      ec = 15'(h / 2);
      n_vec++;
      if (tick !== et || base !== eb || cnt !== ec) begin
        n_err++;
        $display("FAIL cen_hi#%0d: got t=%b b=%b c=%h want t=%b b=%b c=%h",
                 h, tick, base, cnt, et, eb, ec);
      end
      step(1'b0, 1'b0);
      n_vec++;
      if (tick !== 1'b0 || base !== eb || cnt !== ec) begin
        n_err++;
        $display("FAIL cen_lo#%0d: got t=%b b=%b c=%h want t=0 b=%b c=%h",
                 h, tick, base, cnt, eb, ec);
      end
    end
  endtask

  task automatic test_lfo_rst();
    logic et;
    do_reset();
    lfrq = 8'hE0;
    for (int k = 1; k <= 3; k++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    n_vec++;
    if (tick !== 1'b0 || base !== 1'b0 || cnt !== 15'd0) begin
      n_err++;
      $display("FAIL lfo_rst_clear: got t=%b b=%b c=%h want 0 0 0000", tick, base, cnt);
    end
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 1'b0);
      et = (k == 4);
      n_vec++;
      if (tick !== et) begin
        n_err++;
        $display("FAIL lfo_rst_after#%0d: got tick=%b want %b", k, tick, et);
      end
    end
    n_vec++;
    if (base !== 1'b1 || cnt !== 15'd2) begin
      n_err++;
      $display("FAIL lfo_rst_resume: got b=%b c=%h want 1 0002", base, cnt);
    end
  endtask

  task automatic test_rst_mid();
    int guard = 0;
    do_reset();
    lfrq = 8'hD0;
    while (cnt !== 15'h1234 && guard < 20000) begin
      step(1'b1, 1'b0);
      guard++;
    end
    n_vec++;
    if (cnt !== 15'h1234 || base !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_reach: got c=%h b=%b want 1234 1", cnt, base);
    end
    rst = 1'b1;
    step(1'b1, 1'b0);
    rst = 1'b0;
    n_vec++;
    if (tick !== 1'b0 || base !== 1'b0 || cnt !== 15'd0) begin
      n_err++;
      $display("FAIL rst_mid_clear: got t=%b b=%b c=%h want 0 0 0000", tick, base, cnt);
    end
    run_f0("post_rst");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fast();
    test_e14();
    test_cen_toggle();
    test_lfo_rst();
    test_rst_mid();
    test_slow();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jt51_lfo_rate.md
# jt51_lfo_rate

LFO rate generator for the JT51 low-frequency oscillator. It converts the 8-bit LFRQ register value into a `base` square wave whose every edge advances the downstream LFO LFSR noise stage by one step. A one-cycle `tick` pulse accompanies each edge for other LFO consumers. The divider chain has two parts: a fractional mantissa prescaler followed by a power-of-two exponent counter.

## Interface

- No parameters.

- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `cen`  in  1  clock enable; one LFO sample step per cycle in which it is high.
- `lfrq`  in  8  LFRQ register. Bits [7:4] are the exponent `e`; bits [3:0] are the mantissa `m`.
- `lfo_rst`  in  1  synchronous LFO phase clear, from the register-write path.
- `base`  out  1  rate square wave; each edge is one LFSR step.
- `tick`  out  1  one-cycle pulse, registered in the same edge in which `base` toggles.
- `cnt`  out  15  exponent counter value `C`, for debug and verification.

## Operation

- State:
  - `A`: 5-bit mantissa accumulator.
  - `C`: 15-bit exponent counter.
  - `base`, `tick`: registered outputs.
- Reset (`rst`=1): `A`=0, `C`=0, `base`=0, `tick`=0. Reset overrides every other input.
- Prescaler, on each cycle with `cen`=1:
  - `s` = `A` + 16 + `m`, computed 6 bits wide.
  - `p` = `s[5]`.
  - `A` <= `s[4:0]`.
  - Average `p` rate is (16+`m`)/32 per `cen`, giving a range of 1/2 to 31/32.
- Exponent stage, with `mask` = 2^(15−`e`) − 1 (15 bits):
  - `mask` = 0 when `e`=15; `mask` = 0x7FFF when `e`=0.
  - `ev` = `p` AND ((`C` AND `mask`) == `mask`).
  - On `p`=1, `C` <= `C`+1, wrapping modulo 2^15; 0x7FFF wraps to 0.
  - `ev` fires once every 2^(15−`e`) `p` pulses.
- Output, on `ev`: `base` <= ~`base` and `tick` <= 1. Otherwise `tick` <= 0.
- `cen`=0: `A`, `C` and `base` hold, and `tick` <= 0.
- `lfo_rst`=1, when `rst`=0:
  - `A` <= 0, `C` <= 0, `tick` <= 0. This applies regardless of `cen`.
  - `ev` is suppressed that cycle.
  - `base` holds its value; it is not cleared, so no spurious LFSR step is produced.
- `lfrq` is sampled combinationally on each `cen` cycle:
  - A change takes effect at the next `cen`; no internal latch.
  - `A` and `C` are not cleared by a change.
  - Lowering `e` mid-count only widens `mask`, so the next `ev` waits for the wider all-ones pattern.

## Timing

- All outputs are registered. `base`, `tick` and `cnt` update on the clock edge that ends the `cen` cycle producing `ev`, i.e. one cycle of latency.
- `tick` is high for exactly one cycle per `base` edge. It is never high two cycles in a row unless `cen` and `ev` occur on consecutive cycles (e.g. `e`=15, `m`=15).
- Downstream requirement: the LFSR detects edges by comparing against a registered copy of `base`. `base` must therefore never toggle more than once per cycle, which is guaranteed by construction.
- First event after reset with `e`=15, `m`=0:
  - cen#1: `s`=16, `p`=0.
  - cen#2: `s`=32, `p`=1, so `ev` fires.
  - `base` reads 1 after the cen#2 edge.
- Rate: `base` edges per `cen` = (16+`m`)/32 × 2^(`e`−15).
- Toggle periods in `cen` cycles at `m`=0: 2 for `e`=15; 65536 for `e`=0.

## Test plan

- Reset, then `lfrq`=0xF0 with `cen` held high: `base` toggles after cen #2, 4, 6, …, `tick` pulses on the same edges, and `cnt` = 1, 2, 3 after each.
- `lfrq`=0xFF with `cen` held high for 32 cycles after reset: exactly 31 `tick` pulses; `A` returns to 0 after cen #32.
- `lfrq`=0xE0: `tick` after cen #4, 8, 12 (every 2nd `p`). `lfrq`=0x00: first `tick` exactly at cen #65536, and `cnt` wraps to 0 on that edge.
- `cen` toggling 1-0-1-0 with `lfrq`=0xF0: toggles occur only on the 2nd, 4th, … `cen`-high cycle; all state holds while `cen`=0.
- `lfo_rst` pulse with `cen`=1 at the cycle when `ev` would fire (`lfrq`=0xE0, cen #4):
  - No toggle, `tick`=0, `base` keeps its value, `A`=`C`=0.
  - Next `tick` comes 4 `cen` cycles later.
- `rst` asserted mid-count with `cen`=1, `cnt`=0x1234 and `base`=1: next edge gives `base`=0, `tick`=0, `cnt`=0, `A`=0. Post-reset behaviour is identical to the first scenario.
